// File: rtl/axi4lite_master.sv
// AXI4-Lite initiator: converts single-beat valid/ready commands into one
// AXI4-Lite read or write at a time and returns the outcome on a response
// port. All AXI outputs and response fields are registered; cmd_ready is
// the only combinational output.
module axi4lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              areset,
    // command port
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response port
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    // read address channel
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    // read data channel
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    // write address channel
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    // write data channel
    output logic [DATA_W-1:0] wdata,
    output logic              wvalid,
    input  logic              wready,
    // write response channel
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

    state_t            state, state_nx;
    logic              aw_done, w_done, aw_done_nx, w_done_nx;
    logic              aw_hs, w_hs, aw_fin, w_fin;
    logic [ADDR_W-1:0] araddr_nx, awaddr_nx;
    logic [DATA_W-1:0] wdata_nx, rsp_rdata_nx;
    logic              arvalid_nx, awvalid_nx, wvalid_nx, rready_nx, bready_nx;
    logic              rsp_valid_nx, rsp_write_nx;
    logic [1:0]        rsp_resp_nx;

    assign cmd_ready = (state == IDLE) && !areset;
    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    // A channel counts as finished if it completed earlier or completes now,
    // so AW and W may finish in either order or on the same edge.
    assign aw_fin    = aw_done || aw_hs;
    assign w_fin     = w_done || w_hs;

    // State register and registered outputs; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (areset) begin
            state     <= IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            araddr    <= '0;
            awaddr    <= '0;
            wdata     <= '0;
            arvalid   <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            rready    <= 1'b0;
            bready    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
        end else begin
            state     <= state_nx;
            aw_done   <= aw_done_nx;
            w_done    <= w_done_nx;
            araddr    <= araddr_nx;
            awaddr    <= awaddr_nx;
            wdata     <= wdata_nx;
            arvalid   <= arvalid_nx;
            awvalid   <= awvalid_nx;
            wvalid    <= wvalid_nx;
            rready    <= rready_nx;
            bready    <= bready_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_write <= rsp_write_nx;
            rsp_rdata <= rsp_rdata_nx;
            rsp_resp  <= rsp_resp_nx;
        end
    end

    // Next-state selection from the handshakes seen in the current state.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (cmd_valid && cmd_ready) state_nx = cmd_write ? WR : RD_ADDR;
            WR:      if (aw_fin && w_fin)        state_nx = WR_RESP;
            WR_RESP: if (bvalid && bready)       state_nx = RSP;
            RD_ADDR: if (arvalid && arready)     state_nx = RD_DATA;
            RD_DATA: if (rvalid && rready)       state_nx = RSP;
            RSP:     if (rsp_ready)              state_nx = IDLE;
            default:                             state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs; everything holds unless an event updates it.
    always_comb begin
        araddr_nx    = araddr;
        awaddr_nx    = awaddr;
        wdata_nx     = wdata;
        arvalid_nx   = arvalid;
        awvalid_nx   = awvalid;
        wvalid_nx    = wvalid;
        rready_nx    = rready;
        bready_nx    = bready;
        aw_done_nx   = aw_done;
        w_done_nx    = w_done;
        rsp_valid_nx = rsp_valid;
        rsp_write_nx = rsp_write;
        rsp_rdata_nx = rsp_rdata;
        rsp_resp_nx  = rsp_resp;
        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_write) begin
                        awaddr_nx  = cmd_addr;
                        wdata_nx   = cmd_wdata;
                        awvalid_nx = 1'b1;
                        wvalid_nx  = 1'b1;
                        aw_done_nx = 1'b0;
                        w_done_nx  = 1'b0;
                    end else begin
                        araddr_nx  = cmd_addr;
                        arvalid_nx = 1'b1;
                    end
                end
            end
            WR: begin
                if (aw_hs) begin
                    awvalid_nx = 1'b0;
                    aw_done_nx = 1'b1;
                end
                if (w_hs) begin
                    wvalid_nx = 1'b0;
                    w_done_nx = 1'b1;
                end
                if (aw_fin && w_fin) bready_nx = 1'b1;
            end
            WR_RESP: begin
                if (bvalid && bready) begin
                    bready_nx    = 1'b0;
                    rsp_valid_nx = 1'b1;
                    rsp_write_nx = 1'b1;
                    rsp_rdata_nx = '0;
                    rsp_resp_nx  = bresp;
                end
            end
            RD_ADDR: begin
                if (arvalid && arready) begin
                    arvalid_nx = 1'b0;
                    rready_nx  = 1'b1;
                end
            end
            RD_DATA: begin
                if (rvalid && rready) begin
                    rready_nx    = 1'b0;
                    rsp_valid_nx = 1'b1;
                    rsp_write_nx = 1'b0;
                    rsp_rdata_nx = rdata;
                    rsp_resp_nx  = rresp;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_nx = 1'b0;
                    araddr_nx    = '0;
                    awaddr_nx    = '0;
                    wdata_nx     = '0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/axi4lite_master.md
# axi4lite_master

AXI4-Lite master (initiator) that turns single-beat commands from a simple valid/ready command port into AXI4-Lite read or write transactions, one at a time, and returns the result on a response port. It is the initiating end of the same five-channel AXI4-Lite interface implemented by `axi4lite_slave`, and connects port-for-port to it. It is the bus front end for the NoC endpoints and for self-checking benches.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.

- `clk`  in  1  single clock, all logic on rising edge.
- `areset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  transaction address.
- `cmd_wdata`  in  DATA_W  write data; ignored for reads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_write`  out  1  response belongs to a write.
- `rsp_rdata`  out  DATA_W  read data; 0 for writes.
- `rsp_resp`  out  2  captured `rresp`/`bresp`.
- `araddr` out ADDR_W, `arvalid` out 1, `arready` in 1: read address channel.
- `rdata` in DATA_W, `rresp` in 2, `rvalid` in 1, `rready` out 1: read data channel.
- `awaddr` out ADDR_W, `awvalid` out 1, `awready` in 1: write address channel.
- `wdata` out DATA_W, `wvalid` out 1, `wready` in 1: write data channel.
- `bresp` in 2, `bvalid` in 1, `bready` out 1: write response channel.

## Operation
- FSM states: IDLE, WR (AW and/or W outstanding), WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: `cmd_ready`=1. On `cmd_valid&&cmd_ready`, latch `cmd_addr`/`cmd_wdata`/`cmd_write`; go WR (write) or RD_ADDR (read).
- WR: `awvalid` and `wvalid` both raised on entry. Each drops independently the edge after its own handshake (`awvalid&&awready`, `wvalid&&wready`); flags `aw_done`/`w_done` track completion. Either order and same-cycle completion are legal. When both done, go WR_RESP.
- WR_RESP: `bready`=1. On `bvalid`, capture `bresp`, set `rsp_rdata`=0 and `rsp_write`=1, then go RSP.
- RD_ADDR: `arvalid`=1 until `arready`; then go RD_DATA.
- RD_DATA: `rready`=1. On `rvalid`, capture `rdata`/`rresp`, set `rsp_write`=0, then go RSP.
- RSP: `rsp_valid`=1, with response fields held stable until `rsp_ready`; then go IDLE.
- `bvalid`/`rvalid` outside WR_RESP/RD_DATA are ignored (no ready driven).
- `araddr`/`awaddr`/`wdata` driven from latched registers, stable whenever corresponding valid is high; 0 in IDLE.
- One outstanding transaction; no reordering, no wstrb/prot.

## Timing
- All AXI outputs and `rsp_*` are registered. `cmd_ready` is combinational: (state==IDLE)&&!areset.
- Reset (at edge with `areset`=1): state IDLE. All valids/readies 0, `rsp_*`=0, address/data regs 0. `cmd_ready`=0 while `areset` is high.
- Reset mid-transaction: abandons the transaction immediately, with no response emitted. The slave is reset by the same signal.
- Valids raised the cycle after the state entry edge. A valid never drops before its handshake.
- Minimum write latency, with slave readies already high: cmd accept edge N, `awvalid`/`wvalid` high N+1, handshake at edge N+1 → WR_RESP (`bready`) N+2, `bvalid` seen at edge N+2 → `rsp_valid` N+3. Minimum read is also 3 cycles, accept to `rsp_valid`.
- Next command accepted earliest the cycle after the `rsp_valid&&rsp_ready` edge.

## Test plan
- Write 0xA5A5A5A5←0xB5B5B5B5, with slave AW/W ready immediately → `awvalid`/`wvalid` each high exactly 1 cycle. `bready` is high until `bvalid`. `rsp_valid` with `rsp_write`=1, `rsp_resp`=0, `rsp_rdata`=0, 3 cycles after accept.
- Write with `awready` delayed 3 cycles, `wready` immediate → `wvalid` drops after 1 cycle. `awvalid` is held with `awaddr` stable for 4 cycles. `bready` only after both handshakes.
- Read 0xA5A5A5A5 after the above write, on the real `axi4lite_slave` → `rsp_rdata`=0xB5B5B5B5, `rsp_write`=0, `rsp_resp`=0.
- Hold `rsp_ready`=0 for 5 cycles after a read → `rsp_valid` and fields stable, `cmd_ready`=0 throughout. Release → IDLE next cycle.
- Assert `areset` for 1 cycle while in WR with `awvalid` high → all valids/readies 0 next cycle, no `rsp_valid`. The next command completes normally.
- Back-to-back: write then read, `cmd_valid` held high → second command accepted exactly 1 cycle after the first response handshake.
